// File: rtl/addsub_pkg.sv
// Shared constants, types and helpers for the pipelined add/subtract unit.
package addsub_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    typedef struct packed {
        logic cout;
        logic overflow;
        logic zero;
    } flags_t;

    function automatic int unsigned chunk_width(input int unsigned width,
                                                input int unsigned stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/add_slice.sv
// Combinational CHUNK-bit ripple-carry slice.
// Also exposes the carry into its MSB so the top slice can produce signed overflow.
module add_slice #(
    parameter int unsigned CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb_in
);

    logic c;

    always_comb begin
        s        = '0;
        c        = ci;
        c_msb_in = 1'b0;
        for (int i = 0; i < int'(CHUNK); i++) begin
            if (i == int'(CHUNK) - 1) begin
                c_msb_in = c;
            end
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        co = c;
    end

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract: the carry chain is cut into STAGES registered slices.
// Every stage carries the full operand/sum words so skew and deskew fall out of the registers.
module pipelined_addsub
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned CHUNK = chunk_width(WIDTH, STAGES);

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
        $error("pipelined_addsub: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
    end

    logic   en;
    flags_t flags_d;
    flags_t flags_q;

    // Whole pipe advances in lockstep; bubbles are only squeezed at the output.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] in_a;
        logic [WIDTH-1:0] in_b;
        logic [WIDTH-1:0] in_sum;
        logic             in_ci;
        logic             in_v;

        logic [CHUNK-1:0] slice_s;
        logic             slice_co;
        logic             slice_cmsb;
        logic [WIDTH-1:0] sum_d;

        logic [WIDTH-1:0] a_q;
        logic [WIDTH-1:0] b_q;
        logic [WIDTH-1:0] sum_q;
        logic             carry_q;
        logic             valid_q;

        if (k == 0) begin : g_first
            // B is stored already inverted for subtract; the +1 enters as carry-in.
            assign in_a   = a;
            assign in_b   = (sub == MODE_SUB) ? ~b : b;
            assign in_ci  = (sub == MODE_SUB) ? 1'b1 : cin;
            assign in_sum = '0;
            assign in_v   = in_valid;
        end else begin : g_next
            assign in_a   = g_stage[k-1].a_q;
            assign in_b   = g_stage[k-1].b_q;
            assign in_ci  = g_stage[k-1].carry_q;
            assign in_sum = g_stage[k-1].sum_q;
            assign in_v   = g_stage[k-1].valid_q;
        end

        add_slice #(
            .CHUNK(CHUNK)
        ) u_slice (
            .a       (in_a[k*CHUNK +: CHUNK]),
            .b       (in_b[k*CHUNK +: CHUNK]),
            .ci      (in_ci),
            .s       (slice_s),
            .co      (slice_co),
            .c_msb_in(slice_cmsb)
        );

        always_comb begin
            sum_d                   = in_sum;
            sum_d[k*CHUNK +: CHUNK] = slice_s;
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                a_q     <= '0;
                b_q     <= '0;
                sum_q   <= '0;
                carry_q <= 1'b0;
                valid_q <= 1'b0;
            end else if (en) begin
                a_q     <= in_a;
                b_q     <= in_b;
                sum_q   <= sum_d;
                carry_q <= slice_co;
                valid_q <= in_v;
            end
        end

        if (k == STAGES - 1) begin : g_last
            always_comb begin
                flags_d          = '0;
                flags_d.cout     = slice_co;
                flags_d.overflow = slice_cmsb ^ slice_co;
                flags_d.zero     = (sum_d == '0);
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    flags_q <= '0;
                end else if (en) begin
                    flags_q <= flags_d;
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].valid_q;
    assign sum       = g_stage[STAGES-1].sum_q;
    assign cout      = flags_q.cout;
    assign overflow  = flags_q.overflow;
    assign zero      = flags_q.zero;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed bench for pipelined_addsub at WIDTH=32, STAGES=4.
module tb_pipelined_addsub;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;
    logic        overflow;
    logic        zero;

    int checks = 0;
    int errors = 0;

    pipelined_addsub #(
        .WIDTH (32),
        .STAGES(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow),
        .zero     (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Sends one beat into an idle pipe and waits (bounded) for its result.
    task automatic run_one(input logic [31:0] ta, input logic [31:0] tb_v, input logic tcin,
                           input logic tsub, output logic [31:0] rsum, output logic rc,
                           output logic ro, output logic rz, output int lat);
        a = ta;
        b = tb_v;
        cin = tcin;
        sub = tsub;
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        if (out_valid !== 1'b1) lat = -1;
        rsum = sum;
        rc = cout;
        ro = overflow;
        rz = zero;
        tick();
    endtask

    task automatic test_reset;
        reset = 1'b1;
        in_valid = 1'b1;
        a = 32'hFFFF_FFFF;
        b = 32'h1;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({out_valid, sum, cout, overflow, zero} !== 36'h0) begin
                errors++;
                $display("FAIL reset_state cyc%0d: valid=%b sum=%h c=%b o=%b z=%b, need all 0",
                         i, out_valid, sum, cout, overflow, zero);
            end
        end
        reset = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b need 1", in_ready);
        end
    endtask

    task automatic test_add_vectors;
        logic [31:0] rsum;
        logic        rc, ro, rz;
        int          lat;
        // a, b, cin, sub, sum, cout, overflow, zero
        logic [31:0] va [5] = '{32'd1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd5, 32'd7};
        logic [31:0] vb [5] = '{32'd2, 32'd1, 32'd1, 32'd7, 32'd5};
        logic        vci[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic        vsb[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [31:0] es [5] = '{32'd4, 32'h0, 32'h8000_0000, 32'hFFFF_FFFE, 32'd2};
        logic        ec [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic        eo [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic        ez [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            run_one(va[i], vb[i], vci[i], vsb[i], rsum, rc, ro, rz, lat);
            checks++;
            if (lat != 4) begin
                errors++;
                $display("FAIL latency vec%0d: got %0d cycles need 4", i, lat);
            end
            checks++;
            if ({rsum, rc, ro, rz} !== {es[i], ec[i], eo[i], ez[i]}) begin
                errors++;
                $display("FAIL result vec%0d: sum=%h c=%b o=%b z=%b, need sum=%h c=%b o=%b z=%b",
                         i, rsum, rc, ro, rz, es[i], ec[i], eo[i], ez[i]);
            end
        end
    endtask

    task automatic test_backpressure;
        int          sent = 0;
        int          got = 0;
        logic [31:0] held = '0;
        cin = 1'b0;
        sub = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            out_ready = !(cyc >= 6 && cyc <= 8);
            in_valid = (sent < 8);
            a = 32'(sent);
            b = 32'(sent);
            #1;
            if (cyc >= 6 && cyc <= 8) begin
                checks++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL stall_handshake cyc%0d: in_ready=%b out_valid=%b need 0/1",
                             cyc, in_ready, out_valid);
                end
                if (cyc == 6) begin
                    held = sum;
                end else begin
                    checks++;
                    if (sum !== held) begin
                        errors++;
                        $display("FAIL stall_hold cyc%0d: sum=%h need %h", cyc, sum, held);
                    end
                end
            end
            if (out_valid === 1'b1 && out_ready) begin
                checks++;
                if (sum !== 32'(2 * got)) begin
                    errors++;
                    $display("FAIL stream_order beat%0d: sum=%0d need %0d", got, sum, 2 * got);
                end
                got++;
            end
            if (in_valid && in_ready === 1'b1) sent++;
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (got != 8 || sent != 8 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_count: sent=%0d got=%0d out_valid=%b need 8/8/0",
                     sent, got, out_valid);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_midflight_reset;
        logic [31:0] rsum;
        logic        rc, ro, rz;
        int          lat;
        int          seen = 0;
        out_ready = 1'b1;
        cin = 1'b0;
        sub = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            a = 32'(i);
            b = 32'(i);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid !== 1'b0) seen++;
            tick();
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL flush_after_reset: out_valid high on %0d cycles need 0", seen);
        end
        run_one(32'd20, 32'd20, 1'b0, 1'b0, rsum, rc, ro, rz, lat);
        checks++;
        if (lat != 4 || rsum !== 32'd40) begin
            errors++;
            $display("FAIL post_reset_beat: sum=%0d lat=%0d need 40 and 4", rsum, lat);
        end
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        sub = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_add_vectors();
        test_backpressure();
        test_midflight_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
- Parametrised, pipelined add/subtract unit; the next generation of the team's 32-bit ripple-carry adder for the MIPS datapath.
- Splits a WIDTH-bit carry chain into STAGES registered slices, so the carry crosses one slice boundary per clock.
- Adds a subtract mode, status flags (carry, signed overflow, zero) and valid/ready flow control.
- Used by the multi-cycle ALU path and as a timing-closure replacement for the flat adder.

Parameters:
- WIDTH, 32, operand and result width in bits. Must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages and carry slices. Slice width CHUNK = WIDTH/STAGES. Legal range 1..WIDTH.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  unit accepts a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; used only when sub=0.
- sub  input  1  0: a+b+cin; 1: a-b, computed as a+~b+1 with cin ignored.
- out_valid  output  1  result beat valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of the MSB. In subtract mode, 1 means no borrow.
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.
- zero  output  1  sum == 0.

Behaviour:
- Reset is synchronous, active-high, one cycle.
  - Next edge: all valid bits, out_valid, sum, cout, overflow, zero and all pipeline registers are 0.
  - in_ready = 1 in the first cycle after reset deasserts.
  - A reset asserted mid-operation discards every in-flight beat; none is emitted.
- Global advance enable: en = !out_valid || out_ready.
  - in_ready = en. It is combinational and must not depend on in_valid.
  - A beat is accepted on an edge where in_valid && in_ready.
  - When en = 0, every stage register holds, including all data and valid bits.
- Stage k (0..STAGES-1) computes slice k: bits [k*CHUNK +: CHUNK].
  - Inputs are the skewed operand slices plus the carry registered by stage k-1.
  - Stage 0 carry-in = sub ? 1 : cin.
  - The B slice is inverted at acceptance when sub=1.
- Skew and deskew:
  - Operand slices above slice k are delayed in registers until stage k consumes them.
  - Completed low slices are delayed so all slices of one beat emerge together.
- Latency: exactly STAGES cycles from accept to out_valid when there is no backpressure.
  - STAGES=1 is a single registered flat adder with latency 1.
- Throughput: one beat per cycle while out_ready=1.
- Ordering: results leave strictly in acceptance order; no beat is lost or duplicated under any out_ready pattern.
- Output hold: while out_valid=1 and out_ready=0, sum and all flags stay stable.
- Flags are registered with the final stage. overflow is derived from the MSB slice's internal carry into bit WIDTH-1.
- Bubbles: valid=0 bubbles propagate and are squeezed only at the output; no compaction inside the pipe.
- Simultaneous accept and emit in the same cycle is legal and is the steady state.
- Wrap-around is modulo 2^WIDTH; cout reports the lost bit.
- Elaboration must fail if WIDTH % STAGES != 0.

Decomposition:
- Package addsub_pkg holds:
  - mode constants MODE_ADD=1'b0 and MODE_SUB=1'b1;
  - a function returning CHUNK from WIDTH and STAGES;
  - the flag bundle typedef (cout, overflow, zero).
- Sub-module add_slice (parameter CHUNK) is a combinational CHUNK-bit ripple slice.
  - Inputs: a, b, ci.
  - Outputs: s, co, and c_msb_in (carry into the slice MSB, needed for overflow).
  - It is instantiated STAGES times inside a generate loop.

Test Plan (WIDTH=32, STAGES=4):
- Reset: hold reset for 2 cycles with in_valid=1 -> out_valid=0, sum=0 and flags 0 throughout; in_ready=1 in the first cycle after reset deasserts.
- Latency: a=1, b=2, cin=1, sub=0 accepted at cycle 0 -> out_valid first high at cycle 4, sum=4, cout=0, overflow=0, zero=0.
- Full carry chain across every slice boundary: a=0xFFFFFFFF, b=1, cin=0 -> sum=0, cout=1, zero=1, overflow=0.
- Signed overflow: a=0x7FFFFFFF, b=1 -> sum=0x80000000, overflow=1, cout=0.
- Subtract: a=5, b=7, sub=1, cin=1 -> sum=0xFFFFFFFE, cout=0, overflow=0 (cin ignored).
- Backpressure: stream 8 beats a=i, b=i for i=0..7; drop out_ready low on cycles 6-8 -> in_ready low on those cycles, sum stable while stalled, results 0,2,...,14 in order with none lost.
- Mid-flight reset: accept 3 beats, assert reset on the cycle after the third -> out_valid never rises for those beats; a new beat a=20, b=20 then returns 40 after 4 cycles.
